dmem_dump_reader: RTL and testbench
===================================

DMEM_DUMP_READER -- requirements
Module: dmem_dump_reader

Interface
REQ-001 SHALL have parameter N, default 64, meaning data and address width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, meaning number of N-bit words stored (power of two).
REQ-003 SHALL have port CLOCK_50  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port DM_writeEnable  input  1  processor write strobe.
REQ-006 SHALL have port DM_addr  input  N  processor byte address.
REQ-007 SHALL have port DM_writeData  input  N  processor write data.
REQ-008 SHALL have port dump  input  1  level request to start a dump; acted on at the rising edge.
REQ-009 SHALL have port out_valid  output  1  the dump beat is valid.
REQ-010 SHALL have port out_ready  input  1  the consumer accepts the beat.
REQ-011 SHALL have port out_addr  output  N  byte address of the beat.
REQ-012 SHALL have port out_data  output  N  word data of the beat.
REQ-013 SHALL have port busy  output  1  a dump is in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the last beat is accepted.
REQ-015 SHALL have port addr_err  output  1  sticky flag for a misaligned or out-of-range write.

Function
REQ-016 SHALL write DM_writeData into word DM_addr[log2(DEPTH)+2:3] on a cycle with DM_writeEnable=1, DM_addr[2:0]=0 and DM_addr < DEPTH*8.
REQ-017 SHALL drop any write that is misaligned or out of range, and SHALL set addr_err, which stays set until reset.
REQ-018 SHALL detect a dump rising edge from a registered copy of dump; a held-high level SHALL NOT start a second dump.
REQ-019 SHALL use FSM states IDLE, READ, SEND and FINISH.
REQ-020 SHALL move IDLE->READ on a dump rising edge, with index=0.
REQ-021 SHALL perform a synchronous memory read in READ, with 1-cycle latency, then move to SEND.
REQ-022 SHALL hold out_valid=1 in SEND, with out_addr=index*8 and out_data=the word read.
REQ-023 SHALL keep out_addr and out_data stable while out_valid=1 and out_ready=0.
REQ-024 SHALL, when out_valid and out_ready are both 1 in SEND, increment index and return to READ, or go to FINISH if index=DEPTH-1.
REQ-025 SHALL pulse done for one cycle in FINISH and then return to IDLE.
REQ-026 SHALL assert busy in READ, SEND and FINISH.
REQ-027 SHALL ignore a dump rising edge while busy=1; no restart and no queueing.
REQ-028 SHALL accept processor writes during a dump.
REQ-029 SHALL NOT alter a beat already latched in SEND because of such a write; a write to a word not yet visited SHALL appear in that word's later beat.
REQ-030 SHALL give index exactly log2(DEPTH) bits, and index SHALL never wrap during a dump.

Reset
REQ-031 SHALL, on reset, force state to IDLE, index=0, out_valid=0, out_addr=0, out_data=0, busy=0, done=0, addr_err=0, all memory words=0, all dirty bits=0, and the registered dump copy=0.
REQ-032 SHALL abandon a dump when reset is asserted mid-dump, with no done pulse.

Configuration
REQ-033 SHALL, with DUMP_DIRTY_ONLY_EN defined, keep one dirty bit per word, set by an accepted write, and emit beats only for dirty words in ascending index order; READ SHALL skip clean words at one index per cycle.
REQ-034 SHALL, with DUMP_DIRTY_ONLY_EN defined and no dirty words, pulse done without any out_valid.
REQ-035 SHALL, without DUMP_DIRTY_ONLY_EN, emit all DEPTH words and include no dirty logic.

Structure
REQ-036 SHALL place the FSM state enum typedef and the word-offset constant (3) in the shared package dmem_pkg.
REQ-037 SHALL use one sub-module, dmem_array: a DEPTH x N array with one synchronous write port, one synchronous read port and asynchronous clear.

Verification
REQ-038 SHALL verify that writes 0x11 @0x0, 0x22 @0x8 and 0x33 @0x1F8, then a dump with out_ready=1, give 64 beats, with beat 1 = (0x8, 0x22), beat 63 = (0x1F8, 0x33), and done one cycle after the last beat.
REQ-039 SHALL verify that a write to 0x4 and a write to 0x200 are both dropped, addr_err=1, and a dump shows word 0 = 0.
REQ-040 SHALL verify that holding out_ready=0 for 5 cycles in SEND keeps out_valid=1 and out_addr/out_data unchanged.
REQ-041 SHALL verify that a second dump edge at beat 10 has no effect: 64 beats total and one done.
REQ-042 SHALL verify that reset at beat 20 sets busy=0 and out_valid=0 immediately, with no done, and a fresh dump returns all zeros.
REQ-043 SHALL verify, with DUMP_DIRTY_ONLY_EN, that writes to 0x10 and 0x30 give exactly 2 beats, (0x10, ...) then (0x30, ...), followed by done.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared FSM state type and word-offset constant for the dump reader
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    FINISH
  } state_t;

  // Byte address to word index shift (8-byte words)
  localparam int WORD_OFFSET = 3;

endpackage

// File: rtl/dmem_dump_reader_if.sv
// rtl/dmem_dump_reader_if.sv - processor write port and dump stream bundle for dmem_dump_reader
interface dmem_dump_reader_if #(
  parameter int N = 64
);

  logic         DM_writeEnable;
  logic [N-1:0] DM_addr;
  logic [N-1:0] DM_writeData;
  logic         dump;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_addr;
  logic [N-1:0] out_data;
  logic         busy;
  logic         done;
  logic         addr_err;

  // master is the dump reader itself; slave is the processor/consumer side
  modport master (
    input  DM_writeEnable, DM_addr, DM_writeData, dump, out_ready,
    output out_valid, out_addr, out_data, busy, done, addr_err
  );

  modport slave (
    output DM_writeEnable, DM_addr, DM_writeData, dump, out_ready,
    input  out_valid, out_addr, out_data, busy, done, addr_err
  );

endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - DEPTH x N word store, one sync write port, one enabled sync read port, async clear
module dmem_array #(
  parameter int N     = 64,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [N-1:0]  rdata
);

  logic [N-1:0] mem [DEPTH];

  // rdata only moves on re, so a latched beat survives later writes to its word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        mem[waddr] <= wdata;
      end
      if (re) begin
        rdata <= mem[raddr];
      end
    end
  end

endmodule

// File: rtl/dmem_dump_reader.sv
// rtl/dmem_dump_reader.sv - data memory with edge-triggered word dump stream; DUMP_DIRTY_ONLY_EN dumps written words only
module dmem_dump_reader
  import dmem_pkg::*;
#(
  parameter int N     = 64,
  parameter int DEPTH = 64
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         DM_writeEnable,
  input  logic [N-1:0] DM_addr,
  input  logic [N-1:0] DM_writeData,
  input  logic         dump,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_addr,
  output logic [N-1:0] out_data,
  output logic         busy,
  output logic         done,
  output logic         addr_err
);

  localparam int            AW         = $clog2(DEPTH);
  localparam logic [N-1:0]  ADDR_LIMIT = N'(DEPTH) << WORD_OFFSET;
  localparam logic [AW-1:0] LAST       = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] index;
  logic          dump_q;
  logic          wr_ok;
  logic          hit;
  logic          rd_en;
  logic [AW-1:0] wr_word;

  assign wr_word = DM_addr[AW+WORD_OFFSET-1:WORD_OFFSET];
  assign wr_ok   = DM_writeEnable && (DM_addr[WORD_OFFSET-1:0] == '0) && (DM_addr < ADDR_LIMIT);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      addr_err <= 1'b0;
    end else if (DM_writeEnable && !wr_ok) begin
      addr_err <= 1'b1;
    end
  end

`ifdef DUMP_DIRTY_ONLY_EN
  logic [DEPTH-1:0] dirty;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      dirty <= '0;
    end else if (wr_ok) begin
      dirty[wr_word] <= 1'b1;
    end
  end

  assign hit = dirty[index];
`else
  assign hit = 1'b1;
`endif

  assign rd_en = (state == READ) && hit;

  dmem_array #(
    .N     (N),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (CLOCK_50),
    .rst   (reset),
    .we    (wr_ok),
    .waddr (wr_word),
    .wdata (DM_writeData),
    .re    (rd_en),
    .raddr (index),
    .rdata (out_data)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      index     <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dump_q    <= 1'b0;
    end else begin
      dump_q <= dump;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (dump && !dump_q) begin
            state <= READ;
            index <= '0;
            busy  <= 1'b1;
          end
        end
        READ: begin
          if (hit) begin
            state     <= SEND;
            out_valid <= 1'b1;
            out_addr  <= N'(index) << WORD_OFFSET;
          end else if (index == LAST) begin
            state <= FINISH;
            done  <= 1'b1;
          end else begin
            index <= index + AW'(1);
          end
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (index == LAST) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              index <= index + AW'(1);
              state <= READ;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_dump_reader.sv
// tb/tb_dmem_dump_reader.sv - randomized self-checking bench for dmem_dump_reader against a word-level model
module tb_dmem_dump_reader;

  localparam int N     = 64;
  localparam int DEPTH = 64;
`ifdef DUMP_DIRTY_ONLY_EN
  localparam bit DIRTY = 1'b1;
`else
  localparam bit DIRTY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  dmem_dump_reader_if #(.N(N)) ifc ();

  dmem_dump_reader #(.N(N), .DEPTH(DEPTH)) dut (
    .CLOCK_50       (clk),
    .reset          (rst),
    .DM_writeEnable (ifc.DM_writeEnable),
    .DM_addr        (ifc.DM_addr),
    .DM_writeData   (ifc.DM_writeData),
    .dump           (ifc.dump),
    .out_valid      (ifc.out_valid),
    .out_ready      (ifc.out_ready),
    .out_addr       (ifc.out_addr),
    .out_data       (ifc.out_data),
    .busy           (ifc.busy),
    .done           (ifc.done),
    .addr_err       (ifc.addr_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // word-level model: memory image, dirty set, and dump progress
  logic [N-1:0] m_mem [DEPTH];
  bit           m_dirty [DEPTH];
  bit           m_err, m_busy, m_start, m_prev_dump, hold_v, exp_done;
  int           m_idx, done_cnt, cyc, beats, dones, last_acc_cyc, done_cyc;
  logic [N-1:0] hold_a, hold_d;
  logic [N-1:0] cap_addr [DEPTH];
  logic [N-1:0] cap_data [DEPTH];

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit present(input int i);
    return !DIRTY || m_dirty[i];
  endfunction

  function automatic int next_present(input int from);
    for (int i = from; i < DEPTH; i++) begin
      if (present(i)) return i;
    end
    return DEPTH;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      check("rst_valid", ifc.out_valid, 1'b0);
      check("rst_busy", ifc.busy, 1'b0);
      check("rst_done", ifc.done, 1'b0);
      check("rst_addr_err", ifc.addr_err, 1'b0);
      check("rst_out_addr", ifc.out_addr, '0);
      check("rst_out_data", ifc.out_data, '0);
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i]   = '0;
        m_dirty[i] = 1'b0;
      end
      m_err = 0; m_busy = 0; m_start = 0; m_prev_dump = 0; hold_v = 0;
      m_idx = 0; done_cnt = -1;
    end else begin
      cyc++;
      if (m_start) begin
        m_busy  = 1'b1;
        m_start = 1'b0;
      end
      if (done_cnt > 0) done_cnt--;
      exp_done = (done_cnt == 0);
      check("busy", ifc.busy, m_busy);
      check("done", ifc.done, exp_done);
      check("addr_err", ifc.addr_err, m_err);
      if (!m_busy) check("valid_outside_dump", ifc.out_valid, 1'b0);
      if (hold_v) begin
        check("stall_valid", ifc.out_valid, 1'b1);
        check("stall_addr", ifc.out_addr, hold_a);
        check("stall_data", ifc.out_data, hold_d);
      end
      if (ifc.DM_writeEnable) begin
        if (ifc.DM_addr[2:0] == 3'b000 && ifc.DM_addr < 64'(DEPTH * 8)) begin
          m_mem[int'(ifc.DM_addr >> 3)]   = ifc.DM_writeData;
          m_dirty[int'(ifc.DM_addr >> 3)] = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
      if (ifc.out_valid && ifc.out_ready) begin
        int k;
        k = next_present(m_idx);
        if (k >= DEPTH) begin
          check("unexpected_beat", ifc.out_valid, 1'b0);
        end else begin
          check("beat_addr", ifc.out_addr, 64'(k) * 8);
          check("beat_data", ifc.out_data, m_mem[k]);
          if (beats < DEPTH) begin
            cap_addr[beats] = ifc.out_addr;
            cap_data[beats] = ifc.out_data;
          end
          beats++;
          m_idx        = k + 1;
          last_acc_cyc = cyc;
          // remaining clean words are scanned one per cycle before done
          if (next_present(m_idx) >= DEPTH) done_cnt = DEPTH - k;
        end
      end
      hold_v = ifc.out_valid && !ifc.out_ready;
      hold_a = ifc.out_addr;
      hold_d = ifc.out_data;
      if (ifc.dump && !m_prev_dump && !m_busy) begin
        m_start = 1'b1;
        m_idx   = 0;
        beats   = 0;
        if (next_present(0) >= DEPTH) done_cnt = DEPTH + 1;
      end
      if (exp_done) begin
        dones++;
        done_cyc = cyc;
        done_cnt = -1;
        m_busy   = 1'b0;
      end
      m_prev_dump = ifc.dump;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [N-1:0] a, input logic [N-1:0] d);
    ifc.DM_writeEnable = 1'b1;
    ifc.DM_addr        = a;
    ifc.DM_writeData   = d;
    tick();
    ifc.DM_writeEnable = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // drives one write for the coming edge; inside a dump it avoids the beat word and the next one
  task automatic rand_write(input bit in_dump);
    int j, idx;
    ifc.DM_writeEnable = 1'b1;
    ifc.DM_writeData   = {$urandom, $urandom};
    idx = int'(ifc.out_addr >> 3);
    if ($urandom_range(9) == 0) begin
      if ($urandom_range(1) == 0)
        ifc.DM_addr = 64'($urandom_range(DEPTH - 1)) * 8 + 64'($urandom_range(7, 1));
      else
        ifc.DM_addr = 64'(DEPTH * 8) + 64'($urandom_range(1000)) * 8;
    end else begin
      do begin
        j = $urandom_range(DEPTH - 1);
      end while (in_dump && (j == idx || j == idx + 1));
      ifc.DM_addr = 64'(j) * 8;
    end
  endtask

  task automatic run_dump(input bit start, input int ready_pct, input bit wr_en,
                          input int edge_beat, input int rst_beat);
    int n;
    bit fin, edge_done;
    n = 0; fin = 0; edge_done = 0;
    if (start) ifc.dump = 1'b1;
    while (!fin && n < 3000) begin
      ifc.DM_writeEnable = 1'b0;
      if (n == 1) ifc.dump = 1'b0;
      if (n >= 1 && edge_beat >= 0 && !edge_done && beats == edge_beat) begin
        ifc.dump  = 1'b1;
        edge_done = 1'b1;
      end
      if (n >= 1 && rst_beat >= 0 && beats == rst_beat) begin
        ifc.dump = 1'b0;
        rst      = 1'b1;
        #1;
        check("mid_reset_busy", ifc.busy, 1'b0);
        check("mid_reset_valid", ifc.out_valid, 1'b0);
        tick();
        rst = 1'b0;
        fin = 1'b1;
      end else begin
        ifc.out_ready = ($urandom_range(99) < ready_pct);
        if (wr_en && ifc.out_valid && $urandom_range(2) == 0) rand_write(1'b1);
        tick();
        n++;
        if (ifc.done) fin = 1'b1;
      end
    end
    if (!fin) begin
      n_checks++;
      n_fail++;
      $display("FAIL dump_timeout: no done after %0d cycles, required within 3000", n);
    end
    ifc.dump           = 1'b0;
    ifc.DM_writeEnable = 1'b0;
    tick();
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    int d0, nz;
    logic [N-1:0] w0, a, d;
    ifc.DM_writeEnable = 1'b0;
    ifc.DM_addr        = '0;
    ifc.DM_writeData   = '0;
    ifc.dump           = 1'b0;
    ifc.out_ready      = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // three writes then a full-speed dump
    wr(64'h0, 64'h11);
    wr(64'h8, 64'h22);
    wr(64'h1F8, 64'h33);
    d0 = dones;
    run_dump(1, 100, 0, -1, -1);
    check("t1_beats", 64'(beats), DIRTY ? 64'd3 : 64'(DEPTH));
    check("t1_beat0_data", cap_data[0], 64'h11);
    check("t1_beat1_addr", cap_addr[1], 64'h8);
    check("t1_beat1_data", cap_data[1], 64'h22);
    check("t1_last_addr", cap_addr[DIRTY ? 2 : 63], 64'h1F8);
    check("t1_last_data", cap_data[DIRTY ? 2 : 63], 64'h33);
    check("t1_done_latency", 64'(done_cyc - last_acc_cyc), 64'd1);
    check("t1_dones", 64'(dones - d0), 64'd1);

    // misaligned and out-of-range writes are dropped
    do_reset();
    wr(64'h4, 64'hDEAD);
    wr(64'h200, 64'hBEEF);
    check("t2_addr_err", ifc.addr_err, 1'b1);
    d0 = dones;
    run_dump(1, 100, 0, -1, -1);
    if (DIRTY) begin
      check("t2_no_beats", 64'(beats), 64'd0);
    end else begin
      check("t2_word0_addr", cap_addr[0], 64'h0);
      check("t2_word0_data", cap_data[0], 64'h0);
    end
    check("t2_dones", 64'(dones - d0), 64'd1);
    check("t2_addr_err_sticky", ifc.addr_err, 1'b1);

    // consumer stall holds the beat
    w0 = {$urandom, $urandom};
    wr(64'h0, w0);
    for (int i = 1; i < 4; i++) wr(64'(i) * 8, {$urandom, $urandom});
    d0 = dones;
    ifc.out_ready = 1'b0;
    ifc.dump      = 1'b1;
    tick();
    ifc.dump = 1'b0;
    for (int t = 0; t < 10 && !ifc.out_valid; t++) tick();
    check("t3_valid_seen", ifc.out_valid, 1'b1);
    a = ifc.out_addr;
    d = ifc.out_data;
    check("t3_first_addr", a, 64'h0);
    check("t3_first_data", d, w0);
    repeat (5) begin
      tick();
      check("t3_hold_valid", ifc.out_valid, 1'b1);
      check("t3_hold_addr", ifc.out_addr, a);
      check("t3_hold_data", ifc.out_data, d);
    end
    run_dump(0, 100, 0, -1, -1);
    check("t3_dones", 64'(dones - d0), 64'd1);

    // fill every word, then a second dump edge mid-dump is ignored
    for (int i = 0; i < DEPTH; i++) wr(64'(i) * 8, {$urandom, $urandom});
    d0 = dones;
    run_dump(1, 100, 0, 10, -1);
    check("t4_beats", 64'(beats), 64'(DEPTH));
    check("t4_dones", 64'(dones - d0), 64'd1);

    // reset mid-dump abandons it, then memory reads back clear
    d0 = dones;
    run_dump(1, 100, 0, -1, 20);
    check("t5_no_done", 64'(dones - d0), 64'd0);
    d0 = dones;
    run_dump(1, 100, 0, -1, -1);
    nz = 0;
    for (int i = 0; i < beats && i < DEPTH; i++) if (cap_data[i] != '0) nz++;
    check("t5_beats", 64'(beats), DIRTY ? 64'd0 : 64'(DEPTH));
    check("t5_all_zero", 64'(nz), 64'd0);
    check("t5_dones", 64'(dones - d0), 64'd1);

`ifdef DUMP_DIRTY_ONLY_EN
    do_reset();
    wr(64'h10, 64'hA1);
    wr(64'h30, 64'hB2);
    d0 = dones;
    run_dump(1, 100, 0, -1, -1);
    check("t6_beats", 64'(beats), 64'd2);
    check("t6_beat0_addr", cap_addr[0], 64'h10);
    check("t6_beat0_data", cap_data[0], 64'hA1);
    check("t6_beat1_addr", cap_addr[1], 64'h30);
    check("t6_beat1_data", cap_data[1], 64'hB2);
    check("t6_dones", 64'(dones - d0), 64'd1);
`endif

    // random traffic: idle writes, then dumps with random backpressure and concurrent writes
    repeat (12) begin
      int nw;
      nw = $urandom_range(20);
      repeat (nw) begin
        rand_write(1'b0);
        tick();
        ifc.DM_writeEnable = 1'b0;
      end
      d0 = dones;
      run_dump(1, $urandom_range(100, 30), 1, -1, -1);
      check("rand_dones", 64'(dones - d0), 64'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
